// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - byte-wide instruction memory request/response bus
interface if_fetch_unit_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: 4 byte reads per word, static branch prediction
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           stall_i,
  input  logic                 branch_error_i,
  input  logic [31:0]          correct_pc_i,
  if_fetch_unit_if.master      mem,
  output logic                 stallreq_o,
  output logic [31:0]          pc_o,
  output logic [31:0]          inst_o,
  output logic                 predict_result_o,
  output logic [31:0]          next_pc_o
);

  localparam logic [1:0] STALL_PASS = 2'b00;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  if (MEM_TIMEOUT != 0) begin : g_timeout_unsupported
    $error("if_fetch_unit: MEM_TIMEOUT must be 0");
  end

  typedef enum logic [1:0] {FETCH, READY, FLUSH} state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] fetch_pc;
  logic [31:0] inst_buf;
  logic        outstanding;
  logic        mem_req;
  logic        byte_in;
  logic        flush_pending;
  logic        pred_taken;
  logic [31:0] pred_next;
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign byte_in        = mem.mem_rvalid_i && outstanding;
  // A grant seen during a redirect still owes us an rvalid that must be swallowed.
  assign flush_pending  = (outstanding && !mem.mem_rvalid_i) || mem.mem_gnt_i;
  assign mem.mem_req_o  = mem_req;
  assign mem.mem_addr_o = fetch_pc + {30'b0, byte_cnt};

  assign j_imm = {{12{inst_buf[31]}}, inst_buf[19:12], inst_buf[20], inst_buf[30:21], 1'b0};
  assign b_imm = {{20{inst_buf[31]}}, inst_buf[7], inst_buf[30:25], inst_buf[11:8], 1'b0};

  always_comb begin
    pred_taken = 1'b0;
    pred_next  = fetch_pc + 32'd4;
    if (inst_buf[6:0] == OPC_JAL) begin
      pred_taken = 1'b1;
      pred_next  = fetch_pc + j_imm;
    end else if (inst_buf[6:0] == OPC_BRANCH && inst_buf[31]) begin
      pred_taken = 1'b1;
      pred_next  = fetch_pc + b_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next       = state;
    mem_req          = 1'b0;
    stallreq_o       = 1'b1;
    pc_o             = 32'b0;
    inst_o           = 32'b0;
    predict_result_o = 1'b0;
    next_pc_o        = 32'b0;
    case (state)
      FETCH: begin
        mem_req = rst_n && !outstanding && !branch_error_i;
        if (byte_in && byte_cnt == 2'd3) state_next = READY;
      end
      READY: begin
        stallreq_o       = 1'b0;
        pc_o             = fetch_pc;
        inst_o           = inst_buf;
        predict_result_o = pred_taken;
        next_pc_o        = pred_next;
        if (stall_i == STALL_PASS) state_next = FETCH;
      end
      FLUSH: begin
        if (mem.mem_rvalid_i) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    // Inside FLUSH a redirect only retargets; the pending byte still has to drain.
    if (branch_error_i && state != FLUSH) state_next = flush_pending ? FLUSH : FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt    <= 2'd0;
      fetch_pc    <= RESET_PC;
      inst_buf    <= 32'b0;
      outstanding <= 1'b0;
    end else if (branch_error_i) begin
      fetch_pc    <= correct_pc_i;
      byte_cnt    <= 2'd0;
      outstanding <= (state == FLUSH) ? (outstanding && !mem.mem_rvalid_i) : flush_pending;
    end else begin
      case (state)
        FETCH: begin
          if (byte_in) begin
            inst_buf[{byte_cnt, 3'b000} +: 8] <= mem.mem_rdata_i;
            byte_cnt    <= byte_cnt + 2'd1;
            outstanding <= 1'b0;
          end else if (mem_req && mem.mem_gnt_i) begin
            outstanding <= 1'b1;
          end
        end
        READY: begin
          if (stall_i == STALL_PASS) begin
            fetch_pc <= pred_next;
            byte_cnt <= 2'd0;
          end
        end
        FLUSH: begin
          if (mem.mem_rvalid_i) outstanding <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized bench for if_fetch_unit with a transaction-level reference model
module tb_if_fetch_unit;
  localparam logic [1:0] PASS = 2'b00;
  localparam logic [1:0] HOLD = 2'b01;
  localparam logic [1:0] BUBB = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  stall = HOLD;
  logic        branch_error = 1'b0;
  logic [31:0] correct_pc = 32'b0;
  logic        stallreq, predict;
  logic [31:0] pc, inst, next_pc;
  logic        gnt_ok = 1'b0;

  if_fetch_unit_if mem ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .branch_error_i   (branch_error),
    .correct_pc_i     (correct_pc),
    .mem              (mem),
    .stallreq_o       (stallreq),
    .pc_o             (pc),
    .inst_o           (inst),
    .predict_result_o (predict),
    .next_pc_o        (next_pc)
  );

  always #5 clk = ~clk;
  assign mem.mem_gnt_i = mem.mem_req_o && gnt_ok;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem_bytes [logic [31:0]];
  // Reference model: current instruction address, valid bytes received, redirect epoch.
  logic [31:0] m_pc = 32'b0;
  int          m_got = 0;
  int          m_epoch = 0;
  bit          m_due = 1'b0;
  // Memory responder: one pending read tagged with the epoch it was issued in.
  bit          p_valid = 1'b0;
  int          p_cnt = 0;
  logic [7:0]  p_data = 8'b0;
  int          p_epoch = 0;
  // Knobs
  int unsigned gnt_pct = 100, be_pct = 0;
  int unsigned lat_min = 1, lat_max = 1;
  bit          rnd_stall = 1'b0, auto_plant = 1'b0, be_req = 1'b0;
  logic [1:0]  stall_fix = HOLD;
  logic [31:0] be_pc = 32'b0;
  int          cyc = 0, pass_cyc = 0, last_lat = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (!mem_bytes.exists(a)) mem_bytes[a] = 8'($urandom);
    return mem_bytes[a];
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w = 32'b0;
    for (int k = 0; k < 4; k++) w = w | (32'(rd_byte(a + 32'(k))) << (8 * k));
    return w;
  endfunction

  task automatic plant(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem_bytes[a + 32'(k)] = 8'(w >> (8 * k));
  endtask

  task automatic plant_random(input logic [31:0] a);
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 3))
      0: w[6:0] = 7'h6F;
      1: w[6:0] = 7'h63;
      2: w[6:0] = 7'h67;
      default: ;
    endcase
    plant(a, w);
  endtask

  // Immediates rebuilt from their field weights rather than bit concatenation.
  function automatic void ref_predict(input logic [31:0] a, input logic [31:0] w,
                                      output logic tk, output logic [31:0] nx);
    int imm = 4;
    tk = 1'b0;
    if (w[6:0] == 7'h6F) begin
      tk  = 1'b1;
      imm = int'((w >> 21) & 32'h3FF) * 2 + int'((w >> 20) & 32'h1) * 2048
          + int'((w >> 12) & 32'hFF) * 4096 - int'(w >> 31) * (1 << 20);
    end else if (w[6:0] == 7'h63 && w[31]) begin
      tk  = 1'b1;
      imm = int'((w >> 8) & 32'hF) * 2 + int'((w >> 25) & 32'h3F) * 32
          + int'((w >> 7) & 32'h1) * 2048 - 4096;
    end
    nx = a + 32'(imm);
  endfunction

  task automatic step();
    logic [31:0] exp_w, nx, addr;
    logic        tk, req;
    bit          delivered, due_next;
    @(negedge clk);
    cyc++;
    if (rnd_stall) begin
      case ($urandom_range(0, 2))
        0: stall = PASS;
        1: stall = HOLD;
        default: stall = BUBB;
      endcase
    end else begin
      stall = stall_fix;
    end
    if (be_req) begin
      branch_error = 1'b1;
      correct_pc   = be_pc;
      be_req       = 1'b0;
    end else if ($urandom_range(0, 99) < be_pct) begin
      branch_error = 1'b1;
      correct_pc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                 : ($urandom & 32'h0000_0FFF);
    end else begin
      branch_error = 1'b0;
    end
    gnt_ok = ($urandom_range(0, 99) < gnt_pct);
    if (p_valid) p_cnt--;
    mem.mem_rvalid_i = p_valid && (p_cnt == 0);
    mem.mem_rdata_i  = mem.mem_rvalid_i ? p_data : 8'($urandom);
    #1;
    req  = mem.mem_req_o;
    addr = mem.mem_addr_o;
    exp_w = 32'b0; nx = 32'b0; tk = 1'b0;
    if (!stallreq) begin
      exp_w = rd_word(m_pc);
      ref_predict(m_pc, exp_w, tk, nx);
      check_eq("ready_bytes", 32'(m_got), 32'd4);
      check_eq("pc", pc, m_pc);
      check_eq("inst", inst, exp_w);
      check_eq("predict", {31'b0, predict}, {31'b0, tk});
      check_eq("next_pc", next_pc, nx);
      check_eq("ready_no_req", {31'b0, req}, 32'd0);
      if (pass_cyc > 0) begin
        last_lat = cyc - pass_cyc;
        pass_cyc = 0;
      end
    end else begin
      check_eq("bubble", pc | inst | next_pc | {31'b0, predict}, 32'd0);
    end
    if (m_due) check_eq("ready_late", {31'b0, stallreq}, 32'd0);
    if (req) begin
      check_eq("one_in_flight", {31'b0, p_valid}, 32'd0);
      check_eq("fetch_addr", addr, m_pc + 32'(m_got));
    end
    if (!p_valid && m_got < 4 && !branch_error) check_eq("req_expected", {31'b0, req}, 32'd1);

    delivered = mem.mem_rvalid_i;
    if (delivered) p_valid = 1'b0;
    due_next = 1'b0;
    if (branch_error) begin
      m_epoch++;
      m_pc  = correct_pc;
      m_got = 0;
      if (auto_plant) plant_random(m_pc);
    end else if (delivered && p_epoch == m_epoch) begin
      m_got++;
      due_next = (m_got == 4);
    end else if (!stallreq && stall == PASS) begin
      m_pc     = nx;
      m_got    = 0;
      pass_cyc = cyc;
      if (auto_plant) plant_random(m_pc);
    end
    m_due = due_next;
    if (req && gnt_ok) begin
      p_valid = 1'b1;
      p_cnt   = int'($urandom_range(lat_min, lat_max));
      p_data  = rd_byte(addr);
      p_epoch = m_epoch;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (!stallreq) break;
    end
    check_eq("ready_timeout", {31'b0, stallreq}, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] target);
    be_req = 1'b1;
    be_pc  = target;
    step();
  endtask

  initial begin
    int n;
    logic [31:0] hold_pc, hold_inst, hold_next;
    plant(32'h0, 32'h0050_0093);
    plant(32'h10, 32'hFE00_0EE3);
    plant(32'h20, 32'h0080_006F);
    plant(32'h100, 32'h1234_5678);
    mem.mem_rvalid_i = 1'b0;
    mem.mem_rdata_i  = 8'b0;
    #1;
    check_eq("rst_req", {31'b0, mem.mem_req_o}, 32'd0);
    check_eq("rst_stallreq", {31'b0, stallreq}, 32'd1);
    check_eq("rst_outputs", pc | inst | next_pc | {31'b0, predict}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Reset to first instruction with an always-granting, 1-cycle memory
    wait_ready(n);
    check_eq("reset_to_ready", 32'(n), 32'd9);
    check_eq("t1_pc", pc, 32'h0);
    check_eq("t1_inst", inst, 32'h0050_0093);
    check_eq("t1_predict", {31'b0, predict}, 32'd0);
    check_eq("t1_next", next_pc, 32'h4);

    // Taken backward branch, then its predicted target becomes the fetch address
    redirect(32'h10);
    wait_ready(n);
    check_eq("t2_predict", {31'b0, predict}, 32'd1);
    check_eq("t2_next", next_pc, 32'h0000_000C);
    stall_fix = PASS;
    step();
    stall_fix = HOLD;
    step();
    check_eq("t2_req", {31'b0, mem.mem_req_o}, 32'd1);
    check_eq("t2_addr", mem.mem_addr_o, 32'h0000_000C);
    wait_ready(n);
    check_eq("pass_latency", 32'(last_lat), 32'd9);

    // Hold keeps the presented instruction frozen with no memory traffic
    hold_pc = pc; hold_inst = inst; hold_next = next_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_pc", pc, hold_pc);
      check_eq("hold_inst", inst, hold_inst);
      check_eq("hold_next", next_pc, hold_next);
      check_eq("hold_req", {31'b0, mem.mem_req_o}, 32'd0);
    end

    // JAL forward
    redirect(32'h20);
    wait_ready(n);
    check_eq("t3_predict", {31'b0, predict}, 32'd1);
    check_eq("t3_next", next_pc, 32'h0000_0028);

    // Redirect while the second byte is in flight
    lat_min = 3; lat_max = 3;
    stall_fix = PASS;
    step();
    stall_fix = HOLD;
    for (int i = 0; i < 50; i++) begin
      if (m_got == 1 && p_valid) break;
      step();
    end
    check_eq("t5_setup", {31'b0, p_valid}, 32'd1);
    redirect(32'h100);
    for (int i = 0; i < 50; i++) begin
      if (mem.mem_req_o) break;
      step();
    end
    check_eq("t5_addr", mem.mem_addr_o, 32'h0000_0100);
    wait_ready(n);
    check_eq("t5_pc", pc, 32'h0000_0100);
    check_eq("t5_inst", inst, 32'h1234_5678);
    lat_min = 1; lat_max = 1;

    // Asynchronous reset in the middle of a fetch
    stall_fix = PASS;
    step();
    stall_fix = HOLD;
    step();
    #2 rst_n = 1'b0;
    gnt_ok = 1'b0;
    p_valid = 1'b0;
    mem.mem_rvalid_i = 1'b0;
    #1;
    check_eq("t6_req", {31'b0, mem.mem_req_o}, 32'd0);
    check_eq("t6_stallreq", {31'b0, stallreq}, 32'd1);
    check_eq("t6_outputs", pc | inst | next_pc | {31'b0, predict}, 32'd0);
    m_pc = 32'h0; m_got = 0; m_epoch++; m_due = 1'b0; pass_cyc = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    check_eq("t6_restart_addr", mem.mem_addr_o, 32'h0);
    wait_ready(n);
    check_eq("t6_inst", inst, 32'h0050_0093);

    // Random traffic: variable grant/latency, random stall codes and redirects incl. address wrap
    rnd_stall = 1'b1; auto_plant = 1'b1;
    gnt_pct = 60; lat_min = 1; lat_max = 3; be_pct = 4;
    repeat (3000) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
